// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clock-divider controller.
// Holds the FSM state enum, the counter width default and the half-period lookup.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } state_e;

  // Terminal count for one half period: DIV/2 - 1 of the selected ratio.
  function automatic logic [31:0] half_m1(
    input logic [1:0]  sel,
    input int unsigned d0,
    input int unsigned d1,
    input int unsigned d2,
    input int unsigned d3
  );
    int unsigned d;
    unique case (sel)
      2'd0:    d = d0;
      2'd1:    d = d1;
      2'd2:    d = d2;
      default: d = d3;
    endcase
    return d / 2 - 1;
  endfunction

endpackage

// File: rtl/clk_divider_ctl.sv
// Clock-divider controller: 50% duty clk_N with four selectable ratios,
// halt / single-step of whole periods and a tick strobe on each clk_N rise.
// Ports: clk, rst_n (sync, active-low), halt, step, fre_sw[1:0] in;
//        clk_N, tick, halted out (all registered).
module clk_divider_ctl
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DIV0  = 1000,
  parameter int unsigned DIV1  = 100,
  parameter int unsigned DIV2  = 10,
  parameter int unsigned DIV3  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       halt,
  input  logic       step,
  input  logic [1:0] fre_sw,
  output logic       clk_N,
  output logic       tick,
  output logic       halted
);

  localparam int unsigned MAX_DIV01 =
    (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int unsigned MAX_DIV23 =
    (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int unsigned MAX_DIV =
    (MAX_DIV01 > MAX_DIV23) ? MAX_DIV01 : MAX_DIV23;
  localparam longint unsigned MAX_HM1 =
    longint'(MAX_DIV / 2 - 1);

  if ((DIV0 % 2) != 0 || DIV0 < 2 ||
      (DIV1 % 2) != 0 || DIV1 < 2 ||
      (DIV2 % 2) != 0 || DIV2 < 2 ||
      (DIV3 % 2) != 0 || DIV3 < 2) begin : g_bad_div
    $error("clk_divider_ctl: every DIVk must be even and >= 2");
  end

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_w
    $error("clk_divider_ctl: CNT_W must be 1..32");
  end else if (CNT_W < 32 &&
               MAX_HM1 >= (64'd1 << CNT_W)) begin : g_small_w
    $error("clk_divider_ctl: CNT_W too narrow");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hm1_q, hm1_d;
  logic [1:0]       sel_q, sel_d;
  logic             clk_n_q, clk_n_d;
  logic             tick_q, tick_d;
  logic             halted_q, halted_d;

  logic [CNT_W-1:0] hm1_new;
  logic [CNT_W-1:0] hm1_rst;
  logic [CNT_W-1:0] hm1_cur;
  logic             period_start;
  logic             count;
  logic             wrap;

  assign hm1_new = CNT_W'(half_m1(fre_sw,
                    DIV0, DIV1, DIV2, DIV3));
  assign hm1_rst = CNT_W'(half_m1(2'd0,
                    DIV0, DIV1, DIV2, DIV3));

  assign period_start = (cnt_q == '0) && !clk_n_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hm1_d    = hm1_q;
    sel_d    = sel_q;
    clk_n_d  = clk_n_q;
    tick_d   = 1'b0;
    count    = 1'b0;
    hm1_cur  = hm1_q;
    wrap     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (period_start && halt) begin
          state_d = HALTED;
        end else begin
          count = 1'b1;
          // A new period compares against the ratio
          // being latched on this very edge.
          if (period_start) begin
            sel_d   = fre_sw;
            hm1_d   = hm1_new;
            hm1_cur = hm1_new;
          end
        end
      end
      HALTED: begin
        cnt_d   = '0;
        clk_n_d = 1'b0;
        if (!halt) begin
          state_d = RUN;
          sel_d   = fre_sw;
          hm1_d   = hm1_new;
        end else if (step) begin
          state_d = STEP;
          sel_d   = fre_sw;
          hm1_d   = hm1_new;
        end
      end
      STEP: begin
        count = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
        clk_n_d = 1'b0;
      end
    endcase

    if (count) begin
      wrap = (cnt_q == hm1_cur);
      if (wrap) begin
        cnt_d   = '0;
        clk_n_d = !clk_n_q;
        tick_d  = !clk_n_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A step ends on its own falling edge.
    if (state_q == STEP && wrap && clk_n_q) begin
      state_d = HALTED;
    end

    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      hm1_q    <= hm1_rst;
      sel_q    <= 2'd0;
      clk_n_q  <= 1'b0;
      tick_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hm1_q    <= hm1_d;
      sel_q    <= sel_d;
      clk_n_q  <= clk_n_d;
      tick_q   <= tick_d;
      halted_q <= halted_d;
    end
  end

  assign clk_N  = clk_n_q;
  assign tick   = tick_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_clk_divider_ctl.sv
// Scoreboard bench for clk_divider_ctl.
// A period-level model queues expected outputs; a monitor pops per edge.
module tb_clk_divider_ctl;

  localparam int unsigned D0 = 8;
  localparam int unsigned D1 = 4;
  localparam int unsigned D2 = 6;
  localparam int unsigned D3 = 2;

  logic       clk;
  logic       rst_n;
  logic       halt;
  logic       step;
  logic [1:0] fre_sw;
  logic       clk_N;
  logic       tick;
  logic       halted;

  clk_divider_ctl #(
    .CNT_W(8),
    .DIV0 (D0),
    .DIV1 (D1),
    .DIV2 (D2),
    .DIV3 (D3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .halt  (halt),
    .step  (step),
    .fre_sw(fre_sw),
    .clk_N (clk_N),
    .tick  (tick),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic ce;
    logic te;
    logic he;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   n = 0;
  int   nb = 0;
  bit   m_halted = 0;
  bit   started = 0;
  bit   done = 0;
  int   divs[4];

  task automatic push3(input bit c, input bit t,
                       input bit h);
    exp_t e;
    e.ce = c;
    e.te = t;
    e.he = h;
    q.push_back(e);
  endtask

  // One free-running period starting at this edge.
  task automatic push_run(input int h);
    for (int k = 0; k < 2 * h; k++)
      push3(k >= h - 1 && k < 2 * h - 1,
            k == h - 1, 1'b0);
  endtask

  // One stepped period: a latch edge, then 2H
  // counting edges, halted again after the last.
  task automatic push_step(input int h);
    push3(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 2 * h; k++)
      push3(k >= h && k < 2 * h, k == h, k == 2 * h);
  endtask

  task automatic model(input bit r, input bit hl,
                       input bit st,
                       input logic [1:0] f);
    int h;
    h = int'(divs[f]) / 2;
    if (!r) begin
      q.delete();
      push3(1'b0, 1'b0, 1'b0);
      m_halted = 1'b0;
      nb = n + 1;
    end else if (n == nb) begin
      if (!m_halted) begin
        if (hl) begin
          m_halted = 1'b1;
          push3(1'b0, 1'b0, 1'b1);
          nb = n + 1;
        end else begin
          push_run(h);
          nb = n + 2 * h;
        end
      end else if (!hl) begin
        m_halted = 1'b0;
        push3(1'b0, 1'b0, 1'b0);
        nb = n + 1;
      end else if (st) begin
        push_step(h);
        nb = n + 2 * h + 1;
      end else begin
        push3(1'b0, 1'b0, 1'b1);
        nb = n + 1;
      end
    end
    n++;
  endtask

  task automatic cyc(input bit r, input bit hl,
                     input bit st,
                     input logic [1:0] f);
    @(negedge clk);
    rst_n  = r;
    halt   = hl;
    step   = st;
    fre_sw = f;
    model(r, hl, st, f);
    started = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started && !done) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL underflow edge %0d: no expectation",
                   n);
        end else begin
          e = q.pop_front();
          if ({clk_N, tick, halted} !== e) begin
            fails++;
            $display("FAIL outputs edge %0d: clk_N/tick/halted got %b%b%b want %b%b%b",
                     n, clk_N, tick, halted,
                     e.ce, e.te, e.he);
          end
        end
      end
    end
  end

  initial begin
    bit   hl_r;
    logic [1:0] f_r;
    divs[0] = D0;
    divs[1] = D1;
    divs[2] = D2;
    divs[3] = D3;
    rst_n  = 1'b0;
    halt   = 1'b0;
    step   = 1'b0;
    fre_sw = 2'd3;

    // DIV=2 straight out of reset
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 2'd3);
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 2'd3);

    // DIV=8, then ratio switch during high phase
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 2'd0);
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 2'd1);

    // halt raised mid-period at DIV=8
    repeat (11) cyc(1'b1, 1'b0, 1'b0, 2'd0);
    repeat (31) cyc(1'b1, 1'b1, 1'b0, 2'd0);

    // three steps, the second lands inside STEP
    cyc(1'b1, 1'b1, 1'b1, 2'd0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 1'b1, 2'd0);
    repeat (14) cyc(1'b1, 1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 1'b1, 2'd0);
    repeat (20) cyc(1'b1, 1'b1, 1'b0, 2'd0);

    // reset while stepping with clk_N high
    cyc(1'b1, 1'b1, 1'b1, 2'd0);
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 2'd0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 2'd0);

    // halt from reset, then release at DIV=6
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 2'd2);
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 2'd2);

    // randomized traffic
    hl_r = 1'b0;
    f_r  = 2'd0;
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) hl_r = !hl_r;
      if ($urandom_range(0, 14) == 0)
        f_r = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 299) != 0, hl_r,
          $urandom_range(0, 7) == 0, f_r);
    end

    @(posedge clk);
    #2;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
